// File: rtl/fp_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_adder_pkg
// Description : Shared constants and types for the single-precision FP adder
//               back end (normalize / round / pack).
//               EXP_W, MAN_W  field widths of binary32
//               BIAS, EXP_MAX exponent bias and all-ones exponent value
//               fp32_t        packed {sign, exp, man} result word
//               norm_state_t  normalizer FSM states
// Revision    : 1.0 - initial release
// ============================================================================
package fp_adder_pkg;

   localparam int EXP_W   = 8;
   localparam int MAN_W   = 23;
   localparam int BIAS    = 127;
   localparam int EXP_MAX = 255;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
   } fp32_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      NORM  = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } norm_state_t;

endpackage
`default_nettype wire

// File: rtl/fp_round_rne.sv
`default_nettype none
// ============================================================================
// Module      : fp_round_rne
// Description : Combinational rounding stage. Takes a normalized mantissa
//               (hidden bit at MAN_W), the guard/round/sticky bits and the
//               widened exponent; returns the stored fraction, the adjusted
//               exponent and an overflow flag.
//               Macro FP_ROUND_NEAREST_EN:
//                 defined   -> round-to-nearest-even
//                 undefined -> truncation, GRS ignored
// Ports       : man_i  [MAN_W:0]   hidden bit + fraction
//               grs_i  [2:0]       {guard, round, sticky}
//               exp_i  [EXP_W:0]   exponent with one headroom bit
//               man_o  [MAN_W-1:0] rounded stored fraction
//               exp_o  [EXP_W-1:0] rounded exponent field
//               ovf_o              exponent reached all-ones
// Revision    : 1.0 - initial release
// ============================================================================
module fp_round_rne
   import fp_adder_pkg::*;
(
   input  logic [MAN_W:0]   man_i,
   input  logic [2:0]       grs_i,
   input  logic [EXP_W:0]   exp_i,
   output logic [MAN_W-1:0] man_o,
   output logic [EXP_W-1:0] exp_o,
   output logic             ovf_o
);

   localparam logic [EXP_W:0] EXP_ONE = 1;

   logic             inc_w;
   logic [MAN_W+1:0] sum_w;
   logic [EXP_W:0]   exp_adj_w;

`ifdef FP_ROUND_NEAREST_EN
   // Round up above half, and at exactly half only when the LSB is odd.
   assign inc_w = grs_i[2] & (grs_i[1] | grs_i[0] | man_i[0]);
`else
   assign inc_w = 1'b0;
   logic unused_grs;
   assign unused_grs = ^grs_i;
`endif

   assign sum_w = {1'b0, man_i} + {{(MAN_W+1){1'b0}}, inc_w};

   // A carry out of the hidden bit means the mantissa became 10.000...,
   // so renormalize by one position.
   always_comb begin
      if (sum_w[MAN_W+1]) begin
         man_o     = sum_w[MAN_W:1];
         exp_adj_w = exp_i + EXP_ONE;
      end else begin
         man_o     = sum_w[MAN_W-1:0];
         exp_adj_w = exp_i;
      end
   end

   assign exp_o = exp_adj_w[EXP_W-1:0];
   assign ovf_o = (exp_adj_w >= EXP_MAX[EXP_W:0]);

endmodule
`default_nettype wire

// File: rtl/fp_normalize_pack.sv
`default_nettype none
// ============================================================================
// Module      : fp_normalize_pack
// Description : Back end of the binary32 adder. Normalizes the raw sum one
//               shift per cycle, rounds, and packs the IEEE-754 word.
//               Field widths come from fp_adder_pkg (EXP_W=8, MAN_W=23).
//               Macro FP_ROUND_NEAREST_EN selects RNE rounding, otherwise
//               truncation (see fp_round_rne).
// Ports       : clk, reset      clock, synchronous active-high reset
//               in_valid/ready  input handshake (ready only in IDLE)
//               in_sign, in_exponent, in_mantissa[24:0], in_grs[2:0]
//               out_valid/ready output handshake (valid held until taken)
//               out_result      packed {sign, exp, man}
//               out_overflow    saturated to infinity
//               out_underflow   flushed to zero
// Revision    : 1.0 - initial release
// ============================================================================
module fp_normalize_pack
   import fp_adder_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sign,
   input  logic [EXP_W-1:0] in_exponent,
   input  logic [MAN_W+1:0] in_mantissa,
   input  logic [2:0]       in_grs,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic             out_overflow,
   output logic             out_underflow
);

   localparam logic [EXP_W:0] EXP_ONE = 1;

   norm_state_t      state_q;
   logic             sign_q;
   logic [EXP_W:0]   exp_q;      // one headroom bit for post-shift overflow
   logic [MAN_W+1:0] man_q;
   logic [2:0]       grs_q;
   logic             in_ready_q;
   logic             out_valid_q;
   fp32_t            result_q;
   logic             ovf_q;
   logic             unf_q;

   logic [MAN_W-1:0] rnd_man_d;
   logic [EXP_W-1:0] rnd_exp_d;
   logic             rnd_ovf_d;

   fp_round_rne u_round (
      .man_i (man_q[MAN_W:0]),
      .grs_i (grs_q),
      .exp_i (exp_q),
      .man_o (rnd_man_d),
      .exp_o (rnd_exp_d),
      .ovf_o (rnd_ovf_d)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         sign_q      <= 1'b0;
         exp_q       <= '0;
         man_q       <= '0;
         grs_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  sign_q     <= in_sign;
                  exp_q      <= {1'b0, in_exponent};
                  man_q      <= in_mantissa;
                  grs_q      <= in_grs;
                  in_ready_q <= 1'b0;
                  state_q    <= NORM;
               end
            end

            NORM: begin
               if (man_q == '0) begin
                  // Exact cancellation always yields +0.
                  result_q    <= '0;
                  ovf_q       <= 1'b0;
                  unf_q       <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else if (man_q[MAN_W+1]) begin
                  man_q    <= {1'b0, man_q[MAN_W+1:1]};
                  exp_q    <= exp_q + EXP_ONE;
                  grs_q[0] <= grs_q[0] | man_q[0];
                  state_q  <= ROUND;
               end else if (man_q[MAN_W]) begin
                  state_q <= ROUND;
               end else if (exp_q[EXP_W:1] == '0) begin
                  // No denormals: a further left shift would leave the
                  // normal range, so flush keeping the sign.
                  result_q    <= '{sign: sign_q, exp: '0, man: '0};
                  ovf_q       <= 1'b0;
                  unf_q       <= 1'b1;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  // Guard re-enters as the new LSB, round slides into guard.
                  man_q <= {man_q[MAN_W:0], grs_q[2]};
                  grs_q <= {grs_q[1], 1'b0, grs_q[0]};
                  exp_q <= exp_q - EXP_ONE;
               end
            end

            ROUND: begin
               if (rnd_ovf_d) begin
                  result_q <= '{sign: sign_q, exp: '1, man: '0};
               end else begin
                  result_q <= '{sign: sign_q, exp: rnd_exp_d, man: rnd_man_d};
               end
               ovf_q       <= rnd_ovf_d;
               unf_q       <= 1'b0;
               out_valid_q <= 1'b1;
               state_q     <= DONE;
            end

            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready      = in_ready_q;
   assign out_valid     = out_valid_q;
   assign out_result    = result_q;
   assign out_overflow  = ovf_q;
   assign out_underflow = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_normalize_pack.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_normalize_pack
// Description : Directed self-checking bench for fp_normalize_pack with a
//               scoreboard queue of expected results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_normalize_pack;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [7:0]  in_exponent;
   logic [24:0] in_mantissa;
   logic [2:0]  in_grs;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_overflow;
   logic        out_underflow;

   typedef struct packed {
      logic [31:0] res;
      logic        ovf;
      logic        unf;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   lat;

   fp_normalize_pack dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_sign       (in_sign),
      .in_exponent   (in_exponent),
      .in_mantissa   (in_mantissa),
      .in_grs        (in_grs),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_result    (out_result),
      .out_overflow  (out_overflow),
      .out_underflow (out_underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Drive one operand, optionally recording its expected result.
   task automatic send_op(input string tag, input logic s, input logic [7:0] e,
                          input logic [24:0] m, input logic [2:0] g,
                          input bit push, input logic [31:0] r,
                          input logic o, input logic u);
      @(negedge clk);
      chk({tag, "_ready_before"}, {31'b0, in_ready}, 32'd1);
      if (push) sb.push_back('{res: r, ovf: o, unf: u});
      in_valid    = 1'b1;
      in_sign     = s;
      in_exponent = e;
      in_mantissa = m;
      in_grs      = g;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk({tag, "_busy"}, {31'b0, in_ready}, 32'd0);
   endtask

   // Wait (bounded) for out_valid; lat counts the accept edge as cycle 1.
   task automatic wait_valid(input string tag, output int l);
      l = 1;
      while (out_valid !== 1'b1 && l < 64) begin
         @(posedge clk);
         #1;
         l++;
      end
      chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
   endtask

   task automatic check_head(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_result"}, out_result, e.res);
         chk({tag, "_ovf"}, {31'b0, out_overflow}, {31'b0, e.ovf});
         chk({tag, "_unf"}, {31'b0, out_underflow}, {31'b0, e.unf});
      end
   endtask

   task automatic do_op(input string tag, input logic s, input logic [7:0] e,
                        input logic [24:0] m, input logic [2:0] g,
                        input logic [31:0] r, input logic o, input logic u,
                        input int want_lat);
      int l;
      send_op(tag, s, e, m, g, 1'b1, r, o, u);
      wait_valid(tag, l);
      check_head(tag);
      if (want_lat > 0) chk({tag, "_latency"}, l, want_lat);
      @(posedge clk);
      #1;
      chk({tag, "_ready_after"}, {31'b0, in_ready}, 32'd1);
   endtask

   initial begin
      reset       = 1'b1;
      in_valid    = 1'b0;
      in_sign     = 1'b0;
      in_exponent = '0;
      in_mantissa = '0;
      in_grs      = '0;
      out_ready   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready",  {31'b0, in_ready},      32'd1);
      chk("rst_out_valid", {31'b0, out_valid},     32'd0);
      chk("rst_result",    out_result,             32'd0);
      chk("rst_ovf",       {31'b0, out_overflow},  32'd0);
      chk("rst_unf",       {31'b0, out_underflow}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Carry-out: one right shift, 1.5 * 2
      do_op("carry",   1'b0, 8'h7F, 25'h1800000, 3'b000, 32'h40400000, 1'b0, 1'b0, 3);
      // Already normalized, negative
      do_op("norm0",   1'b1, 8'h81, 25'h0800000, 3'b000, 32'hC0800000, 1'b0, 1'b0, 3);
      // One left shift
      do_op("lshift1", 1'b0, 8'h80, 25'h0400000, 3'b000, 32'h3F800000, 1'b0, 1'b0, 0);
      // Fifteen left shifts
      do_op("lshift15",1'b0, 8'h90, 25'h0000100, 3'b000, 32'h40800000, 1'b0, 1'b0, 0);
      // Exact zero with negative input sign -> +0
      do_op("zero",    1'b1, 8'h85, 25'h0000000, 3'b000, 32'h00000000, 1'b0, 1'b0, 0);
`ifdef FP_ROUND_NEAREST_EN
      do_op("rnd_up",  1'b0, 8'h7F, 25'h0FFFFFF, 3'b100, 32'h40000000, 1'b0, 1'b0, 3);
      do_op("rnd_odd", 1'b0, 8'h7F, 25'h0800001, 3'b100, 32'h3F800002, 1'b0, 1'b0, 3);
`else
      do_op("rnd_up",  1'b0, 8'h7F, 25'h0FFFFFF, 3'b100, 32'h3FFFFFFF, 1'b0, 1'b0, 3);
      do_op("rnd_odd", 1'b0, 8'h7F, 25'h0800001, 3'b100, 32'h3F800001, 1'b0, 1'b0, 3);
`endif
      // Tie with even LSB stays put in both modes
      do_op("rnd_tie", 1'b0, 8'h7F, 25'h0800000, 3'b100, 32'h3F800000, 1'b0, 1'b0, 3);
      // Overflow to infinity
      do_op("ovf",     1'b0, 8'hFE, 25'h1000000, 3'b000, 32'h7F800000, 1'b1, 1'b0, 0);
      // Underflow, positive and negative
      do_op("unf_pos", 1'b0, 8'h02, 25'h0000001, 3'b000, 32'h00000000, 1'b0, 1'b1, 0);
      do_op("unf_neg", 1'b1, 8'h02, 25'h0000001, 3'b000, 32'h80000000, 1'b0, 1'b1, 0);

      // Backpressure: result must hold while out_ready is low
      out_ready = 1'b0;
      send_op("bp", 1'b0, 8'h7F, 25'h1800000, 3'b000, 1'b1, 32'h40400000, 1'b0, 1'b0);
      wait_valid("bp", lat);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_hold_result", out_result, 32'h40400000);
         chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
         chk("bp_hold_ready", {31'b0, in_ready}, 32'd0);
      end
      check_head("bp");
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_drain_valid", {31'b0, out_valid}, 32'd0);
      chk("bp_drain_ready", {31'b0, in_ready}, 32'd1);

      // Reset mid-NORM discards the operand
      send_op("rstnorm", 1'b0, 8'h90, 25'h0000100, 3'b000, 1'b0, 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rstnorm_valid", {31'b0, out_valid}, 32'd0);
      chk("rstnorm_ready", {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      reset = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("rstnorm_no_output", {31'b0, out_valid}, 32'd0);

      // Normal operation resumes after the reset
      do_op("post_rst", 1'b0, 8'h80, 25'h0400000, 3'b000, 32'h3F800000, 1'b0, 1'b0, 0);

      chk("sb_drained", sb.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
